// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and load-address helper for the 8-point IFFT engine.
package fft_pkg;

  localparam int unsigned DATA_W    = 9;
  localparam int unsigned N         = 8;
  localparam int unsigned LOG2N     = 3;
  localparam int          TWIDDLE_C = 181;  // 256/sqrt(2), applied as ((s >>> 3) * C) >>> 5

  typedef enum logic [1:0] {
    StLoad    = 2'd0,
    StCompute = 2'd1,
    StUnload  = 2'd2
  } state_e;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly with inverse twiddle W8^-k and 1/2 scaling per stage.
module ifft_butterfly
  import fft_pkg::*;
(
  input  logic [1:0]        k,
  input  logic [DATA_W-1:0] x0_re,
  input  logic [DATA_W-1:0] x0_im,
  input  logic [DATA_W-1:0] x1_re,
  input  logic [DATA_W-1:0] x1_im,
  output logic [DATA_W-1:0] a0_re,
  output logic [DATA_W-1:0] a0_im,
  output logic [DATA_W-1:0] a1_re,
  output logic [DATA_W-1:0] a1_im
);

  localparam int unsigned SumW = DATA_W + 1;
  localparam logic signed [15:0] CMul = 16'(TWIDDLE_C);

  // Multiply a 10-bit sum by cos(pi/4), saturated to the 9-bit data range.
  function automatic logic signed [SumW-1:0] mul_c(input logic signed [SumW-1:0] s);
    logic signed [15:0] p;
    logic signed [15:0] q;
    p = 16'(s >>> 3) * CMul;
    q = p >>> 5;
    if (q > 16'sd255) begin
      return 10'sd255;
    end else if (q < -16'sd256) begin
      return -10'sd256;
    end
    return 10'(q);
  endfunction

  logic signed [SumW-1:0] x0r, x0i, x1r, x1i;
  logic signed [SumW-1:0] diff, sum;
  logic signed [SumW-1:0] y_re, y_im;

  assign x0r  = 10'($signed(x0_re));
  assign x0i  = 10'($signed(x0_im));
  assign x1r  = 10'($signed(x1_re));
  assign x1i  = 10'($signed(x1_im));
  assign diff = x1r - x1i;
  assign sum  = x1r + x1i;

  // y is kept at 10 bits so negating -256 cannot wrap.
  always_comb begin
    y_re = x1r;
    y_im = x1i;
    unique case (k)
      2'd0: begin y_re = x1r;          y_im = x1i;        end
      2'd1: begin y_re = mul_c(diff);  y_im = mul_c(sum); end
      2'd2: begin y_re = -x1i;         y_im = x1r;        end
      2'd3: begin y_re = -mul_c(sum);  y_im = mul_c(diff); end
    endcase
  end

  assign a0_re = 9'((x0r + y_re) >>> 1);
  assign a0_im = 9'((x0i + y_im) >>> 1);
  assign a1_re = 9'((x0r - y_re) >>> 1);
  assign a1_im = 9'((x0i - y_im) >>> 1);

endmodule

// File: rtl/ifft8_engine.sv
// 8-point in-place IFFT: bit-reversed load, 12 sequential butterflies, natural-order unload.
module ifft8_engine
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] in_re,
  input  logic [8:0] in_im,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_re,
  output logic [8:0] out_im,
  output logic       busy
);

  state_e state_q, state_d;
  logic [LOG2N-1:0]  ld_cnt_q, ld_cnt_d;
  logic [LOG2N-1:0]  out_cnt_q, out_cnt_d;
  logic [3:0]        bf_cnt_q, bf_cnt_d;
  logic [DATA_W-1:0] mem_re_q [N];
  logic [DATA_W-1:0] mem_re_d [N];
  logic [DATA_W-1:0] mem_im_q [N];
  logic [DATA_W-1:0] mem_im_d [N];
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  logic [1:0]        stage, idx, tw_k;
  logic [LOG2N-1:0]  addr0, addr1;
  logic [DATA_W-1:0] a0_re, a0_im, a1_re, a1_im;

  assign stage = bf_cnt_q[3:2];
  assign idx   = bf_cnt_q[1:0];

  // Pair (g*span + j, g*span + j + half) with twiddle j*4/half for the current stage.
  always_comb begin
    addr0 = {idx, 1'b0};
    addr1 = {idx, 1'b1};
    tw_k  = 2'd0;
    case (stage)
      2'd1: begin
        addr0 = {idx[1], 1'b0, idx[0]};
        addr1 = {idx[1], 1'b1, idx[0]};
        tw_k  = {idx[0], 1'b0};
      end
      2'd2: begin
        addr0 = {1'b0, idx};
        addr1 = {1'b1, idx};
        tw_k  = idx;
      end
      default: ;
    endcase
  end

  ifft_butterfly u_bfly (
    .k     (tw_k),
    .x0_re (mem_re_q[addr0]),
    .x0_im (mem_im_q[addr0]),
    .x1_re (mem_re_q[addr1]),
    .x1_im (mem_im_q[addr1]),
    .a0_re (a0_re),
    .a0_im (a0_im),
    .a1_re (a1_re),
    .a1_im (a1_im)
  );

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    out_cnt_d = out_cnt_q;
    bf_cnt_d  = bf_cnt_q;
    mem_re_d  = mem_re_q;
    mem_im_d  = mem_im_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          mem_re_d[bit_rev(ld_cnt_q)] = in_re;
          mem_im_d[bit_rev(ld_cnt_q)] = in_im;
          ld_cnt_d = ld_cnt_q + 3'd1;
          if (ld_cnt_q == 3'd7) begin
            state_d = StCompute;
          end
        end
      end
      StCompute: begin
        mem_re_d[addr0] = a0_re;
        mem_im_d[addr0] = a0_im;
        mem_re_d[addr1] = a1_re;
        mem_im_d[addr1] = a1_im;
        bf_cnt_d = bf_cnt_q + 4'd1;
        if (bf_cnt_q == 4'd11) begin
          bf_cnt_d  = 4'd0;
          out_cnt_d = '0;
          state_d   = StUnload;
        end
      end
      StUnload: begin
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 3'd1;
          if (out_cnt_q == 3'd7) begin
            state_d = StLoad;
          end
        end
      end
      default: state_d = StLoad;
    endcase
    in_ready_d  = (state_d == StLoad);
    out_valid_d = (state_d == StUnload);
    busy_d      = (state_d == StCompute);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      ld_cnt_q    <= '0;
      out_cnt_q   <= '0;
      bf_cnt_q    <= '0;
      mem_re_q    <= '{default: '0};
      mem_im_q    <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      out_cnt_q   <= out_cnt_d;
      bf_cnt_q    <= bf_cnt_d;
      mem_re_q    <= mem_re_d;
      mem_im_q    <= mem_im_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_re    = mem_re_q[out_cnt_q];
  assign out_im    = mem_im_q[out_cnt_q];

endmodule
